// File: rtl/dffn_pipe_bank.sv
// Falling-edge capture pipeline bank: DEPTH stages of WIDTH-bit data plus a valid
// tag per stage, async init to INIT_VAL, stall, flush and a full scan chain.
module dffn_pipe_bank #(
  parameter int                 WIDTH    = 8,
  parameter int                 DEPTH    = 2,
  parameter logic [WIDTH-1:0]   INIT_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLKN,
  input  logic             SETN,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_IN,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_OUT,
  output logic             SO
);

  localparam int STRIDE = WIDTH + 1;
  localparam int L      = DEPTH * STRIDE;

  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [L-1:0]     chain_cur;
  logic [L-1:0]     chain_shf;

  // Chain bit k: stage i occupies k = i*STRIDE (valid) then i*STRIDE+1+j (data bit j);
  // a shift moves every bit from k to k+1, SI enters at k=0, SO is bit L-1.
  always_comb begin
    chain_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      chain_cur[i*STRIDE] = v_q[i];
      for (int j = 0; j < WIDTH; j++) begin
        chain_cur[i*STRIDE+1+j] = d_q[i][j];
      end
    end
    chain_shf = {chain_cur[L-2:0], SI};

    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end

    if (SE) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_d[i] = chain_shf[i*STRIDE];
        for (int j = 0; j < WIDTH; j++) begin
          d_d[i][j] = chain_shf[i*STRIDE+1+j];
        end
      end
    end else if (FLUSH) begin
      v_d = '0;
    end else if (EN) begin
      d_d[0] = D;
      v_d[0] = VLD_IN;
      for (int i = 1; i < DEPTH; i++) begin
        d_d[i] = d_q[i-1];
        v_d[i] = v_q[i-1];
      end
    end
  end

  always_ff @(negedge CLKN or negedge SETN) begin
    if (!SETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= INIT_VAL;
      end
      v_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
      v_q <= v_d;
    end
  end

  assign Q       = d_q[DEPTH-1];
  assign VLD_OUT = v_q[DEPTH-1];
  assign SO      = d_q[DEPTH-1][WIDTH-1];

endmodule

// File: tb/tb_dffn_pipe_bank.sv
// Bench for dffn_pipe_bank (WIDTH=8, DEPTH=3, INIT_VAL=8'hA5): directed scenarios
// plus randomized traffic, all compared against a queue-based reference model.
module tb_dffn_pipe_bank;

  localparam int W = 8;
  localparam int N = 3;
  localparam logic [W-1:0] INIT = 8'hA5;

  logic         CLKN;
  logic         SETN;
  logic         EN;
  logic         FLUSH;
  logic [W-1:0] D;
  logic         VLD_IN;
  logic         SE;
  logic         SI;
  logic [W-1:0] Q;
  logic         VLD_OUT;
  logic         SO;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pipe[0] is the stage nearest the input, each entry {valid, data}.
  logic [W:0] pipe[$];

  dffn_pipe_bank #(.WIDTH(W), .DEPTH(N), .INIT_VAL(INIT)) dut (
    .CLKN(CLKN), .SETN(SETN), .EN(EN), .FLUSH(FLUSH), .D(D), .VLD_IN(VLD_IN),
    .SE(SE), .SI(SI), .Q(Q), .VLD_OUT(VLD_OUT), .SO(SO)
  );

  // clock / watchdog
  initial CLKN = 1'b1;
  always #5 CLKN = ~CLKN;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < N; i++) pipe.push_back({1'b0, INIT});
  endtask

  // Scan: serialise in chain order (SI side first), insert SI, drop the SO end.
  task automatic model_shift(input logic si);
    bit chain[$];
    chain.delete();
    for (int i = 0; i < N; i++) begin
      chain.push_back(pipe[i][W]);
      for (int j = 0; j < W; j++) chain.push_back(pipe[i][j]);
    end
    chain.push_front(si);
    void'(chain.pop_back());
    for (int i = 0; i < N; i++) begin
      pipe[i][W] = chain.pop_front();
      for (int j = 0; j < W; j++) pipe[i][j] = chain.pop_front();
    end
  endtask

  task automatic model_edge();
    if (!SETN) model_reset();
    else if (SE) model_shift(SI);
    else if (FLUSH) begin
      for (int i = 0; i < N; i++) pipe[i][W] = 1'b0;
    end else if (EN) begin
      pipe.push_front({VLD_IN, D});
      void'(pipe.pop_back());
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_q"},   32'(Q),       32'(pipe[N-1][W-1:0]));
    check({tag, "_vld"}, 32'(VLD_OUT), 32'(pipe[N-1][W]));
    check({tag, "_so"},  32'(SO),      32'(pipe[N-1][W-1]));
  endtask

  // driver: called at posedge+1; applies inputs, checks after the falling edge
  // and again after the following rising edge (which must change nothing).
  task automatic step(input logic se, input logic si, input logic fl, input logic en,
                      input logic vi, input logic [W-1:0] d, input string tag);
    SE = se; SI = si; FLUSH = fl; EN = en; VLD_IN = vi; D = d;
    @(negedge CLKN);
    model_edge();
    #1 check_outs(tag);
    @(posedge CLKN);
    #1 check_outs({tag, "_rise"});
  endtask

  task automatic pulse_reset(input string tag);
    #1 SETN = 1'b0;
    model_reset();
    #1 check_outs(tag);
    #1 SETN = 1'b1;
  endtask

  task automatic fill3();
    step(0, 0, 0, 1, 1, 8'h11, "fill1");
    step(0, 0, 0, 1, 1, 8'h22, "fill2");
    step(0, 0, 0, 1, 1, 8'h33, "fill3");
  endtask

  initial begin
    SETN = 1'b0; SE = 0; SI = 0; FLUSH = 0; EN = 0; VLD_IN = 0; D = '0;
    model_reset();
    @(posedge CLKN); #1;
    check_outs("por");
    SETN = 1'b1;

    // 1: async reset mid-cycle, held through 4 edges with SE/EN active
    step(0, 0, 0, 1, 1, 8'h5A, "pre1");
    step(0, 0, 0, 1, 1, 8'h3C, "pre2");
    #1 SETN = 1'b0;
    model_reset();
    #1 check_outs("rst_async");
    check("rst_q_const", 32'(Q), 32'h0000_00A5);
    check("rst_so_const", 32'(SO), 32'd1);
    for (int k = 0; k < 4; k++) step(k[0], 1, 0, 1, 1, 8'hFF, "rst_hold");
    SETN = 1'b1;

    // 2: stream with 3-edge latency
    fill3();
    check("lat_q11", 32'(Q), 32'h11);
    check("lat_vld", 32'(VLD_OUT), 32'd1);
    step(0, 0, 0, 1, 1, 8'h44, "stream4");
    check("lat_q22", 32'(Q), 32'h22);

    // 3: stall
    pulse_reset("rst3");
    fill3();
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 8'hEE, "stall");
    check("stall_q", 32'(Q), 32'h11);
    step(0, 0, 0, 1, 0, 8'h99, "resume");
    check("resume_q", 32'(Q), 32'h22);

    // 4: flush, then flush together with scan
    pulse_reset("rst4");
    fill3();
    step(0, 0, 1, 1, 1, 8'h77, "flush");
    check("flush_q", 32'(Q), 32'h11);
    check("flush_vld", 32'(VLD_OUT), 32'd0);
    fill3();
    step(1, 1, 1, 1, 1, 8'h77, "flush_se");

    // 5: scan out the reset image then the injected pattern
    pulse_reset("rst5");
    for (int k = 0; k < 2 * N * (W + 1); k++) begin
      logic [26:0] pat;
      pat = 27'b101_1011_0110_1101_1011_0110_1101;
      step(1, pat[k % 27], 0, 0, 0, 8'h00, "scan");
    end

    // 6: reset between edges 2 and 3 of a stream, then full latency again
    SETN = 1'b1;
    step(0, 0, 0, 1, 1, 8'h61, "s6a");
    step(0, 0, 0, 1, 1, 8'h62, "s6b");
    pulse_reset("s6_rst");
    step(0, 0, 0, 1, 1, 8'h63, "s6c");
    step(0, 0, 0, 1, 1, 8'h64, "s6d");
    check("s6_vld_pre", 32'(VLD_OUT), 32'd0);
    step(0, 0, 0, 1, 1, 8'h65, "s6e");
    check("s6_q", 32'(Q), 32'h63);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
      step($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
